// File: rtl/debounce_sync_if.sv
// Signal bundle between a debounced-input consumer and debounce_sync.
// master drives the raw input and clear; slave (the debouncer) returns the qualified level.
interface debounce_sync_if;
    logic       din;
    logic       glitch_clr;
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch_cnt;

    modport master (
        output din,
        output glitch_clr,
        input  level,
        input  rise,
        input  fall,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  glitch_clr,
        output level,
        output rise,
        output fall,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous input and accepts a level change only after it has been
// stable for STABLE_CYC synchronized samples; rejected candidates are counted as glitches.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    debounce_sync_if.slave   bus
);

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [7:0]             r_glitch_cnt;
    logic                   w_din_s;
    logic                   w_glitch;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the first synchronizer flop touches the asynchronous din.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din};
        end
    end

    assign w_din_s  = r_sync[SYNC_STAGES-1];
    assign w_glitch = ((r_state == S_WAIT_HI) && !w_din_s) ||
                      ((r_state == S_WAIT_LO) &&  w_din_s);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_LO;
            r_cnt        <= '0;
            r_level      <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LO: begin
                    if (w_din_s) begin
                        r_state <= S_WAIT_HI;
                        r_cnt   <= 8'd1;
                    end
                end
                S_WAIT_HI: begin
                    if (!w_din_s) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HI: begin
                    if (!w_din_s) begin
                        r_state <= S_WAIT_LO;
                        r_cnt   <= 8'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (w_din_s) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_LO;
                    r_cnt   <= '0;
                end
            endcase

            // A clear coinciding with a glitch keeps that glitch.
            if (bus.glitch_clr) begin
                r_glitch_cnt <= w_glitch ? 8'd1 : 8'd0;
            end else if (w_glitch) begin
                r_glitch_cnt <= sat_inc(r_glitch_cnt);
            end
        end
    end

    assign bus.level      = r_level;
    assign bus.rise       = r_rise;
    assign bus.fall       = r_fall;
    assign bus.busy       = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
    assign bus.glitch_cnt = r_glitch_cnt;

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on din, legal range 2..4.
REQ-002 SHALL have parameter STABLE_CYC, default 16: consecutive synchronized samples needed to accept a level change, legal range 2..255.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on posedge clk.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port din, input, 1: raw asynchronous input (switch/button/flop output).
REQ-006 SHALL have port glitch_clr, input, 1: synchronous clear of glitch_cnt.
REQ-007 SHALL have port level, output, 1: debounced registered level.
REQ-008 SHALL have port rise, output, 1: one-cycle pulse on accepted 0->1.
REQ-009 SHALL have port fall, output, 1: one-cycle pulse on accepted 1->0.
REQ-010 SHALL have port busy, output, 1: high while a candidate change is being qualified.
REQ-011 SHALL have port glitch_cnt, output, 8: saturating count of rejected candidate changes.

Function
REQ-012 SHALL pass din through a chain of SYNC_STAGES flops; din_s is the last stage; no other logic samples din.
REQ-013 SHALL implement FSM states S_LO, S_WAIT_HI, S_HI, S_WAIT_LO plus an 8-bit qualification counter cnt.
REQ-014 In S_LO: din_s=1 -> S_WAIT_HI with cnt<=1; otherwise hold.
REQ-015 In S_WAIT_HI: din_s=0 -> S_LO, cnt<=0, glitch event; din_s=1 and cnt==STABLE_CYC-1 -> S_HI, level<=1, rise<=1; otherwise cnt<=cnt+1.
REQ-016 In S_HI: din_s=0 -> S_WAIT_LO with cnt<=1; otherwise hold.
REQ-017 In S_WAIT_LO: din_s=1 -> S_HI, cnt<=0, glitch event; din_s=0 and cnt==STABLE_CYC-1 -> S_LO, level<=0, fall<=1; otherwise cnt<=cnt+1.
REQ-018 Latency from a din edge to a level change SHALL be exactly SYNC_STAGES+STABLE_CYC posedges, with din stable throughout (18 at defaults).
REQ-019 rise and fall SHALL each be high for exactly one cycle, in the first cycle level shows its new value; they are never high together.
REQ-020 busy SHALL be 1 exactly when the state is S_WAIT_HI or S_WAIT_LO; decoded from the state register only.
REQ-021 Each glitch event SHALL increment glitch_cnt by 1, saturating at 255; no wrap.
REQ-022 glitch_clr=1 SHALL set glitch_cnt to 0 on the next edge; glitch_clr and a glitch event in the same cycle SHALL yield glitch_cnt=1.
REQ-023 level SHALL not change while in a wait state; a rejected candidate produces no pulse.
REQ-024 cnt SHALL never exceed STABLE_CYC-1.

Reset
REQ-025 rstn=0 SHALL immediately force all sync flops=0, state=S_LO, cnt=0, level=0, rise=0, fall=0, glitch_cnt=0; busy=0 follows.
REQ-026 Reset mid-qualification or in S_HI SHALL discard progress with no rise/fall pulse during or at release.
REQ-027 If din is held 1 through reset release, level SHALL rise with one rise pulse SYNC_STAGES+STABLE_CYC posedges after the first posedge with rstn=1.

Verification
REQ-028 Defaults, din 0->1 held: level=1 and rise=1 for one cycle at posedge 18 after the change; busy=1 for the 15 cycles before it.
REQ-029 din high for 5 cycles, then low: level stays 0, no rise, glitch_cnt=1, state back to S_LO.
REQ-030 From S_HI, din bounces 1-0-1-0 at 3-cycle intervals, then holds 0: glitch_cnt increments once per rejected bounce, one fall pulse 18 posedges after the final falling edge.
REQ-031 Generate 300 glitches: glitch_cnt saturates at 255; glitch_clr pulse -> 0; clr together with a glitch -> 1.
REQ-032 Assert rstn=0 at cnt=10 in S_WAIT_HI with din=1, release after 3 cycles: all outputs 0 during reset, rise occurs 18 posedges after release.
REQ-033 STABLE_CYC=2, SYNC_STAGES=3: din step gives level change after exactly 5 posedges; a 1-cycle din pulse after sync gives glitch_cnt=1.
